// File: rtl/flash_attr_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module : flash_attr_renderer_pkg
// Brief  : Shared constants and helpers for the text-mode attribute renderer:
//          attribute byte field positions, palette level codes and the
//          16-colour CGA palette lookup.
// Rev    : 1.0  initial release
// ============================================================================
package flash_attr_renderer_pkg;

    // Attribute byte layout
    localparam int ATTR_BLINK_BIT = 7;
    localparam int ATTR_BG_MSB    = 6;
    localparam int ATTR_BG_LSB    = 4;
    localparam int ATTR_FG_MSB    = 3;
    localparam int ATTR_FG_LSB    = 0;

    // Palette index whose green channel is dimmed (brown instead of dark yellow)
    localparam logic [3:0] C_IDX_BROWN = 4'd6;

    // Per-channel intensity level, resolved to a real value by the consumer
    // once the channel width is known.
    typedef enum logic [1:0] {
        LVL_ZERO = 2'd0,
        LVL_ONE3 = 2'd1,
        LVL_TWO3 = 2'd2,
        LVL_FULL = 2'd3
    } level_e;

    typedef struct packed {
        level_e r;
        level_e g;
        level_e b;
    } pal_t;

    // Level for one channel given its colour bit and the intensity bit
    function automatic level_e chan_level(input logic bit_on, input logic inten);
        level_e lvl;
        if (bit_on) lvl = inten ? LVL_FULL : LVL_TWO3;
        else        lvl = inten ? LVL_ONE3 : LVL_ZERO;
        return lvl;
    endfunction

    // CGA palette: idx = {I,R,G,B}
    function automatic pal_t palette(input logic [3:0] idx);
        pal_t p;
        p.r = chan_level(idx[2], idx[3]);
        p.g = chan_level(idx[1], idx[3]);
        p.b = chan_level(idx[0], idx[3]);
        if (idx == C_IDX_BROWN) p.g = LVL_ONE3;
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flash_attr_renderer_phase.sv
`default_nettype none
// ============================================================================
// Module : flash_phase_latch
// Brief  : Synchronises the free-running flash level, latches it once per
//          frame on the falling edge of vsync, and divides latched phase
//          changes down to a slower cursor blink phase.
// Rev    : 1.0  initial release
// ============================================================================
module flash_phase_latch #(
    parameter int CURSOR_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic flashIn,
    input  logic vsync,
    output logic flashPhase,
    output logic cursorPhase
);

    localparam int CNT_W = (CURSOR_DIV > 1) ? $clog2(CURSOR_DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CURSOR_DIV - 1);

    logic             r_sync1;
    logic             r_flash_sync;
    logic             r_vsync_prev;
    logic             r_flash_phase;
    logic             r_cursor_phase;
    logic [CNT_W-1:0] r_cursor_cnt;

    logic             w_vsync_edge;
    logic             w_phase_change;

    assign w_vsync_edge   = r_vsync_prev & ~vsync;
    assign w_phase_change = w_vsync_edge & (r_flash_sync != r_flash_phase);

    // Two-flop synchroniser for the asynchronous flash level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1      <= 1'b0;
            r_flash_sync <= 1'b0;
        end else begin
            r_sync1      <= flashIn;
            r_flash_sync <= r_sync1;
        end
    end

    // Frame-boundary latch of the flash phase; vsync idles high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vsync_prev  <= 1'b1;
            r_flash_phase <= 1'b0;
        end else begin
            r_vsync_prev <= vsync;
            if (w_vsync_edge) r_flash_phase <= r_flash_sync;
        end
    end

    // Cursor divider: counts latched phase changes, toggles on wrap
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cursor_cnt   <= '0;
            r_cursor_phase <= 1'b0;
        end else if (w_phase_change) begin
            if (r_cursor_cnt == C_CNT_LAST) begin
                r_cursor_cnt   <= '0;
                r_cursor_phase <= ~r_cursor_phase;
            end else begin
                r_cursor_cnt <= r_cursor_cnt + 1'b1;
            end
        end
    end

    assign flashPhase  = r_flash_phase;
    assign cursorPhase = r_cursor_phase;

endmodule
`default_nettype wire

// File: rtl/flash_attr_renderer.sv
`default_nettype none
// ============================================================================
// Module : flash_attr_renderer
// Brief  : Applies the frame-latched flash phase to the character-attribute
//          pixel stream and decodes attribute + glyph bit into CGA RGB through
//          a two-stage, non-stalling pipeline.
// Rev    : 1.0  initial release
// ============================================================================
module flash_attr_renderer
    import flash_attr_renderer_pkg::*;
#(
    parameter int COLOR_W    = 4,
    parameter int CURSOR_DIV = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flashIn,
    input  logic                   vsync,
    input  logic                   validIn,
    input  logic                   blankIn,
    input  logic                   glyphBit,
    input  logic [7:0]             attr,
    input  logic                   cursorHit,
    input  logic                   blinkEn,
    output logic [3*COLOR_W-1:0]   rgbOut,
    output logic                   validOut,
    output logic                   blankOut,
    output logic                   flashPhase
);

    localparam logic [COLOR_W-1:0] C_FULL = COLOR_W'((1 << COLOR_W) - 1);
    localparam logic [COLOR_W-1:0] C_TWO3 = COLOR_W'((((1 << COLOR_W) - 1) * 2) / 3);
    localparam logic [COLOR_W-1:0] C_ONE3 = COLOR_W'(((1 << COLOR_W) - 1) / 3);

    // Resolve a palette level code to this instance's channel width
    function automatic logic [COLOR_W-1:0] lvl_val(input level_e lvl);
        logic [COLOR_W-1:0] v;
        case (lvl)
            LVL_FULL: v = C_FULL;
            LVL_TWO3: v = C_TWO3;
            LVL_ONE3: v = C_ONE3;
            default:  v = '0;
        endcase
        return v;
    endfunction

    logic                 w_flash_phase;
    logic                 w_cursor_phase;

    // Stage 1 registers
    logic                 r_s1_valid;
    logic                 r_s1_blank;
    logic                 r_s1_glyph;
    logic [7:0]           r_s1_attr;
    logic                 r_s1_cursor;

    // Stage 2 registers
    logic [3*COLOR_W-1:0] r_rgb;
    logic                 r_valid_out;
    logic                 r_blank_out;

    // Stage 2 decode wires
    logic [3:0]           w_fg_idx;
    logic [3:0]           w_bg_idx;
    logic                 w_hide;
    logic                 w_on;
    logic                 w_swap;
    logic [3:0]           w_idx;
    pal_t                 w_pal;
    logic [3*COLOR_W-1:0] w_rgb;

    flash_phase_latch #(
        .CURSOR_DIV (CURSOR_DIV)
    ) u_phase (
        .clock       (clock),
        .reset       (reset),
        .flashIn     (flashIn),
        .vsync       (vsync),
        .flashPhase  (w_flash_phase),
        .cursorPhase (w_cursor_phase)
    );

    // Stage 1: capture the incoming pixel and its attribute context
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_blank  <= 1'b0;
            r_s1_glyph  <= 1'b0;
            r_s1_attr   <= '0;
            r_s1_cursor <= 1'b0;
        end else begin
            r_s1_valid  <= validIn;
            r_s1_blank  <= blankIn;
            r_s1_glyph  <= glyphBit;
            r_s1_attr   <= attr;
            r_s1_cursor <= cursorHit;
        end
    end

    // Stage 2 decode: blink hide, cursor swap, colour index select, palette
    always_comb begin
        w_fg_idx = r_s1_attr[ATTR_FG_MSB:ATTR_FG_LSB];
        w_bg_idx = blinkEn ? {1'b0, r_s1_attr[ATTR_BG_MSB:ATTR_BG_LSB]}
                           : r_s1_attr[ATTR_BLINK_BIT:ATTR_BG_LSB];
        w_hide   = blinkEn & r_s1_attr[ATTR_BLINK_BIT] & ~w_flash_phase;
        w_on     = r_s1_glyph & ~w_hide;
        w_swap   = r_s1_cursor & w_cursor_phase;
        w_idx    = (w_on ^ w_swap) ? w_fg_idx : w_bg_idx;
        w_pal    = palette(w_idx);
        w_rgb    = {lvl_val(w_pal.r), lvl_val(w_pal.g), lvl_val(w_pal.b)};
    end

    // Stage 2: register colour; blanked or empty slots output black
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rgb       <= '0;
            r_valid_out <= 1'b0;
            r_blank_out <= 1'b0;
        end else begin
            r_rgb       <= (r_s1_valid && !r_s1_blank) ? w_rgb : '0;
            r_valid_out <= r_s1_valid;
            r_blank_out <= r_s1_blank;
        end
    end

    assign rgbOut     = r_rgb;
    assign validOut   = r_valid_out;
    assign blankOut   = r_blank_out;
    assign flashPhase = w_flash_phase;

endmodule
`default_nettype wire

// File: tb/tb_flash_attr_renderer.sv
`default_nettype none
// ============================================================================
// Module : tb_flash_attr_renderer
// Brief  : Self-checking bench for flash_attr_renderer (COLOR_W=4,
//          CURSOR_DIV=2) with an abstract per-cycle reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_flash_attr_renderer;

    localparam int COLOR_W    = 4;
    localparam int CURSOR_DIV = 2;
    localparam int HIST       = 4096;

    logic        clock;
    logic        reset;
    logic        flashIn;
    logic        vsync;
    logic        validIn;
    logic        blankIn;
    logic        glyphBit;
    logic [7:0]  attr;
    logic        cursorHit;
    logic        blinkEn;
    logic [11:0] rgbOut;
    logic        validOut;
    logic        blankOut;
    logic        flashPhase;

    int total = 0;
    int bad   = 0;

    flash_attr_renderer #(
        .COLOR_W    (COLOR_W),
        .CURSOR_DIV (CURSOR_DIV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flashIn    (flashIn),
        .vsync      (vsync),
        .validIn    (validIn),
        .blankIn    (blankIn),
        .glyphBit   (glyphBit),
        .attr       (attr),
        .cursorHit  (cursorHit),
        .blinkEn    (blinkEn),
        .rgbOut     (rgbOut),
        .validOut   (validOut),
        .blankOut   (blankOut),
        .flashPhase (flashPhase)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: CGA palette as a plain table, rules applied directly
    // ------------------------------------------------------------------
    logic [11:0] cga [16];
    initial begin
        cga[0]  = 12'h000; cga[1]  = 12'h00A; cga[2]  = 12'h0A0; cga[3]  = 12'h0AA;
        cga[4]  = 12'hA00; cga[5]  = 12'hA0A; cga[6]  = 12'hA50; cga[7]  = 12'hAAA;
        cga[8]  = 12'h555; cga[9]  = 12'h55F; cga[10] = 12'h5F5; cga[11] = 12'h5FF;
        cga[12] = 12'hF55; cga[13] = 12'hF5F; cga[14] = 12'hFF5; cga[15] = 12'hFFF;
    end

    function automatic logic [11:0] model_rgb(input logic v, input logic b, input logic g,
                                              input logic [7:0] a, input logic c,
                                              input logic bl, input logic ph, input logic cu);
        int  fg, bg;
        logic on;
        if (!v || b) return 12'h000;
        fg = int'(a[3:0]);
        bg = bl ? int'(a[6:4]) : int'(a[7:4]);
        on = g && !(bl && a[7] && !ph);
        return ((on ? 1 : 0) != ((c && cu) ? 1 : 0)) ? cga[fg] : cga[bg];
    endfunction

    // Per-posedge history since the last reset release
    logic       fin_h [HIST];
    logic       vs_h  [HIST];
    logic       bl_h  [HIST];
    logic       pv_h  [HIST];
    logic       pb_h  [HIST];
    logic       pg_h  [HIST];
    logic [7:0] pa_h  [HIST];
    logic       pc_h  [HIST];
    logic       ph_a  [HIST];
    logic       cu_a  [HIST];
    int         n     = 0;
    int         flips = 0;
    logic       m_ph  = 1'b0;

    // Record inputs each clock; the latched phase is the synchronised flash
    // level (two samples old) taken at each vsync falling edge.
    always @(posedge clock) begin
        if (!reset) begin
            n     = 0;
            flips = 0;
            m_ph  = 1'b0;
        end else if (n < HIST) begin
            logic prev_vs, newph;
            fin_h[n] = flashIn;  vs_h[n] = vsync;   bl_h[n] = blinkEn;
            pv_h[n]  = validIn;  pb_h[n] = blankIn; pg_h[n] = glyphBit;
            pa_h[n]  = attr;     pc_h[n] = cursorHit;
            prev_vs  = (n == 0) ? 1'b1 : vs_h[n-1];
            if (prev_vs && !vsync) begin
                newph = (n >= 2) ? fin_h[n-2] : 1'b0;
                if (newph != m_ph) flips++;
                m_ph = newph;
            end
            ph_a[n] = m_ph;
            cu_a[n] = ((flips / CURSOR_DIV) % 2) == 1;
            n++;
        end
    end

    // Compare DUT against the model shortly after every active edge
    always @(posedge clock) begin
        logic [11:0] e_rgb;
        logic        e_v, e_b, e_ph;
        #2;
        e_rgb = 12'h000; e_v = 1'b0; e_b = 1'b0; e_ph = 1'b0;
        if (reset) begin
            if (n >= 1) e_ph = ph_a[n-1];
            if (n >= 2) begin
                e_v   = pv_h[n-2];
                e_b   = pb_h[n-2];
                e_rgb = model_rgb(pv_h[n-2], pb_h[n-2], pg_h[n-2], pa_h[n-2], pc_h[n-2],
                                  bl_h[n-1], ph_a[n-2], cu_a[n-2]);
            end
        end
        chk("cmp_rgb",   32'(rgbOut),     32'(e_rgb));
        chk("cmp_valid", 32'(validOut),   32'(e_v));
        chk("cmp_blank", 32'(blankOut),   32'(e_b));
        chk("cmp_phase", 32'(flashPhase), 32'(e_ph));
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic set_pix(input logic v, input logic b, input logic g,
                           input logic [7:0] a, input logic c);
        validIn = v; blankIn = b; glyphBit = g; attr = a; cursorHit = c;
    endtask

    task automatic frame(input logic f);
        flashIn = f;
        repeat (4) @(negedge clock);
        vsync = 1'b0;
        @(negedge clock);
        vsync = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        reset = 1'b0; flashIn = 1'b0; vsync = 1'b1; blinkEn = 1'b1;
        set_pix(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("reset_valid", 32'(validOut), 32'd0);
        chk("reset_rgb",   32'(rgbOut),   32'd0);

        // Back-to-back pixels, one per cycle
        set_pix(1'b1, 1'b0, 1'b1, 8'h1E, 1'b0);
        @(negedge clock); glyphBit = 1'b0;
        @(negedge clock); chk("fg_yellow", 32'(rgbOut), 32'hFF5);
        chk("fg_valid", 32'(validOut), 32'd1);
        glyphBit = 1'b1;
        @(negedge clock); chk("bg_blue", 32'(rgbOut), 32'h00A);
        @(negedge clock); chk("fg_yellow2", 32'(rgbOut), 32'hFF5);

        // Blinking glyph hidden in phase 0, shown after the next frame latch
        set_pix(1'b1, 1'b0, 1'b1, 8'h9F, 1'b0);
        repeat (2) @(negedge clock); chk("blink_hidden", 32'(rgbOut), 32'h00A);
        frame(1'b1);
        chk("blink_shown", 32'(rgbOut), 32'hFFF);
        chk("phase_one",   32'(flashPhase), 32'd1);

        // Flash activity without a frame edge must not disturb anything
        repeat (1000) begin
            @(negedge clock);
            flashIn = ~flashIn;
        end
        chk("hold_phase", 32'(flashPhase), 32'd1);
        chk("hold_rgb",   32'(rgbOut), 32'hFFF);
        flashIn = 1'b1;

        // Bright background mode, brown exception, blanking, bubble
        blinkEn = 1'b0;
        set_pix(1'b1, 1'b0, 1'b0, 8'h9F, 1'b0);
        repeat (2) @(negedge clock); chk("bright_bg", 32'(rgbOut), 32'h55F);
        set_pix(1'b1, 1'b0, 1'b1, 8'h06, 1'b0);
        repeat (2) @(negedge clock); chk("brown", 32'(rgbOut), 32'hA50);
        set_pix(1'b1, 1'b1, 1'b1, 8'h06, 1'b0);
        repeat (2) @(negedge clock); chk("blank_rgb", 32'(rgbOut), 32'h000);
        chk("blank_out", 32'(blankOut), 32'd1);
        set_pix(1'b0, 1'b0, 1'b1, 8'h1E, 1'b0);
        repeat (2) @(negedge clock); chk("bubble", 32'(validOut), 32'd0);

        // Mid-stream reset
        set_pix(1'b1, 1'b0, 1'b1, 8'h1E, 1'b0);
        repeat (2) @(negedge clock); chk("pre_reset", 32'(rgbOut), 32'hFF5);
        reset = 1'b0;
        #1;
        chk("async_rgb",   32'(rgbOut),     32'd0);
        chk("async_valid", 32'(validOut),   32'd0);
        chk("async_phase", 32'(flashPhase), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock); chk("rel_plus1", 32'(validOut), 32'd0);
        @(negedge clock); chk("rel_plus2", 32'(validOut), 32'd1);
        chk("rel_rgb", 32'(rgbOut), 32'hFF5);

        // Cursor divider: swap after 2nd latched change, unswap after 4th
        cursorHit = 1'b1;
        frame(1'b1); chk("cur_flip1", 32'(rgbOut), 32'hFF5);
        frame(1'b0); chk("cur_flip2", 32'(rgbOut), 32'h00A);
        frame(1'b1); chk("cur_flip3", 32'(rgbOut), 32'h00A);
        frame(1'b0); chk("cur_flip4", 32'(rgbOut), 32'hFF5);

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
